display_scan_driver: RTL and testbench
======================================

# display_scan_driver

Time-multiplexed front end for the baggage-drop status display and drop actuator. It consumes the four 7-segment codes and the drop-activated level produced by the display/drop decision logic. It drives one shared segment bus with per-digit enables, scanned with anti-ghost blanking. It also converts the drop-activated level into a bounded solenoid pulse followed by a mandatory cooldown.

## Interface
Parameters:
- DIV, 50000: clock cycles per digit slot; legal range 2 or more.
- BLANK, 2: cycles at the start of each slot with all digits disabled; legal range 0 to DIV-1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out (the segment "off" level becomes 7'b111_1111).
- DROP_PULSE, 1000: solenoid on-time in cycles; legal range 1 or more.
- DROP_COOLDOWN, 5000: lockout after each pulse in cycles; legal range 1 or more.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- seg1 .. seg4  in  7 each  segment codes, active-high, bit 6 = segment g. seg1 is the leftmost digit.
- drop_req  in  1  drop-activated level from the decision logic.
- seg_out  out  7  shared segment bus.
- dig_en  out  4  one-hot digit enable, active-high; bit 0 = seg1.
- solenoid  out  1  drop actuator drive.
- busy  out  1  high while the actuator is in FIRE or COOL.

## Operation
- Slot counter cnt counts 0..DIV-1. Digit index idx (2 bits) advances mod 4 when cnt = DIV-1.
- Snapshot: snap1..snap4 load seg1..seg4 together on the cycle cnt = DIV-1 and idx = 3. A frame therefore never tears mid-scan. Input changes take effect from the next frame.
- Slot decode:
  - cnt < BLANK: dig_en = 0 and seg_out = off level.
  - Otherwise: dig_en = 1 << idx and seg_out = snap[idx], inverted if SEG_ACTIVE_LOW.
- seg_out and dig_en are registered outputs. They show the decode of cnt/idx/snap from the previous cycle.
- Actuator FSM has three states:
  - IDLE: solenoid = 0. A rising edge of drop_req (drop_req = 1, req_prev = 0) moves to FIRE and loads tmr = DROP_PULSE-1.
  - FIRE: solenoid = 1. tmr decrements each cycle. At tmr = 0, move to COOL and load tmr = DROP_COOLDOWN-1.
  - COOL: solenoid = 0. At tmr = 0, move to IDLE.
- Edge handling:
  - Rising edges seen during FIRE or COOL are discarded, not queued.
  - A level still high on return to IDLE does not re-fire. A new rising edge is required.
- req_prev is a register updated every cycle from drop_req, in every state.
- Counter widths:
  - cnt uses $clog2(DIV) bits.
  - tmr uses $clog2(max(DROP_PULSE, DROP_COOLDOWN)) bits, minimum 1.
  - No arithmetic wraps outside these ranges.

## Timing
- Reset values:
  - cnt = 0, idx = 0, snap1..4 = 0, dig_en = 0, seg_out = off level.
  - State = IDLE, tmr = 0, solenoid = 0, busy = 0.
  - req_prev = 1, so a drop_req held high through reset release does not fire.
- The first frame after reset displays blank (snap = 0), lasting 4*DIV cycles.
- Frame period = 4*DIV cycles. Each digit is lit for DIV-BLANK cycles per frame.
- Drop latency: a rising edge sampled at edge k makes solenoid = 1 and busy = 1 after edge k.
  - solenoid stays high for exactly DROP_PULSE cycles.
  - busy stays high for DROP_PULSE + DROP_COOLDOWN cycles.
- The scan counter and the actuator are independent. Neither stalls the other.
- Reset asserted mid-operation overrides everything on that edge. solenoid drops on the same edge, and any pulse in progress is abandoned.

## Structure
- Shared include/package `display_defs`:
  - actuator state encodings (IDLE = 2'd0, FIRE = 2'd1, COOL = 2'd2);
  - SEG_BLANK = 7'b000_0000;
  - digit count constant 4.
- One natural sub-module, `drop_actuator`, holding the FSM, tmr, req_prev, solenoid and busy. The scan, snapshot and output registers stay in the top module.

## Test plan
- Reset then scan (DIV=8, BLANK=2, seg1..4 = 7'h39, 7'h5C, 7'h38, 7'h5E):
  - cycles 0–31: dig_en never lit with nonzero seg_out.
  - frame 2: each digit is enabled 6 of 8 cycles in order 0001, 0010, 0100, 1000, with matching codes.
- Mid-frame change: change seg3 while idx = 1. The new code appears only in the following frame; the current frame still shows the old code.
- SEG_ACTIVE_LOW=1: blank slots show seg_out = 7'h7F. Digit 1 with code 7'h39 shows 7'h46.
- Drop pulse (DROP_PULSE=3, DROP_COOLDOWN=5): drop_req goes 0 then 1 at edge k.
  - solenoid = 1 for edges k..k+2.
  - busy = 1 for 8 cycles.
  - holding drop_req high afterward produces no second pulse.
- Lockout: toggle drop_req low/high during FIRE and during COOL. No extra pulse occurs. A new edge after busy falls fires normally.
- Reset interactions:
  - assert rst during FIRE: solenoid = 0 next edge, state IDLE.
  - drop_req held high across reset release: no fire until it drops and rises again.

Source files
------------

// File: rtl/display_defs.sv
// Shared definitions for the display scan driver and drop actuator.
// Holds actuator state encodings, the blank segment code and digit count.
package display_defs;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;

    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,
        ACT_FIRE = 2'd1,
        ACT_COOL = 2'd2
    } act_state_e;

endpackage

// File: rtl/drop_actuator.sv
// Converts the drop-activated level into a bounded solenoid pulse followed by
// a mandatory cooldown. Only a fresh rising edge seen while idle fires.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   drop_req - drop-activated level from the decision logic
//   solenoid - actuator drive, high for DROP_PULSE cycles per accepted edge
//   busy     - high while firing or cooling down
module drop_actuator
    import display_defs::*;
#(
    parameter int unsigned DROP_PULSE    = 1000,
    parameter int unsigned DROP_COOLDOWN = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic drop_req,
    output logic solenoid,
    output logic busy
);

    localparam int unsigned TMR_MAX = (DROP_PULSE > DROP_COOLDOWN) ? DROP_PULSE : DROP_COOLDOWN;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    act_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             req_prev_q;
    logic             solenoid_q, solenoid_d;
    logic             busy_q, busy_d;
    logic             rise_c;

    // req_prev resets high so a level held through reset release cannot fire
    assign rise_c = drop_req & ~req_prev_q;

    // State, timer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACT_IDLE;
            tmr_q      <= '0;
            req_prev_q <= 1'b1;
            solenoid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            req_prev_q <= drop_req;
            solenoid_q <= solenoid_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; edges arriving in FIRE/COOL are simply dropped
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            ACT_IDLE: begin
                if (rise_c) begin
                    state_d = ACT_FIRE;
                    tmr_d   = TMR_W'(DROP_PULSE - 1);
                end
            end
            ACT_FIRE: begin
                if (tmr_q == '0) begin
                    state_d = ACT_COOL;
                    tmr_d   = TMR_W'(DROP_COOLDOWN - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ACT_COOL: begin
                if (tmr_q == '0) begin
                    state_d = ACT_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ACT_IDLE;
                tmr_d   = '0;
            end
        endcase
        solenoid_d = (state_d == ACT_FIRE);
        busy_d     = (state_d != ACT_IDLE);
    end

    assign solenoid = solenoid_q;
    assign busy     = busy_q;

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan with anti-ghost blanking, plus the
// drop actuator pulse generator.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   seg1..seg4     - active-high segment codes (bit 6 = g), seg1 leftmost
//   drop_req       - drop-activated level
//   seg_out        - shared segment bus (inverted when SEG_ACTIVE_LOW)
//   dig_en         - one-hot digit enable, bit 0 = seg1
//   solenoid, busy - actuator drive and lockout indication
module display_scan_driver
    import display_defs::*;
#(
    parameter int unsigned DIV            = 50000,
    parameter int unsigned BLANK          = 2,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned DROP_PULSE     = 1000,
    parameter int unsigned DROP_COOLDOWN  = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] seg1,
    input  logic [SEG_W-1:0] seg2,
    input  logic [SEG_W-1:0] seg3,
    input  logic [SEG_W-1:0] seg4,
    input  logic             drop_req,
    output logic [SEG_W-1:0] seg_out,
    output logic [3:0]       dig_en,
    output logic             solenoid,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(DIV);
    // XOR mask doubles as the "off" level on the bus
    localparam logic [SEG_W-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [SEG_W-1:0] snap_q [NUM_DIGITS];
    logic [SEG_W-1:0] snap_d [NUM_DIGITS];
    logic [SEG_W-1:0] seg_out_q, seg_out_d;
    logic [3:0]       dig_en_q, dig_en_d;
    logic             slot_last_c;
    logic             in_blank_c;

    assign slot_last_c = (cnt_q == CNT_W'(DIV - 1));

    // Blanking window at the start of each slot (absent when BLANK = 0)
    if (BLANK == 0) begin : g_no_blank
        assign in_blank_c = 1'b0;
    end else begin : g_blank
        assign in_blank_c = (cnt_q < CNT_W'(BLANK));
    end

    // Scan, snapshot and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_out_q <= SEG_OFF;
            dig_en_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= SEG_BLANK;
            end
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_out_q <= seg_out_d;
            dig_en_q  <= dig_en_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // Slot advance, frame-aligned snapshot and slot decode
    always_comb begin
        cnt_d  = slot_last_c ? '0 : cnt_q + CNT_W'(1);
        idx_d  = slot_last_c ? idx_q + 2'd1 : idx_q;
        snap_d = snap_q;
        // Load all four codes together at the end of the last slot so a frame never tears
        if (slot_last_c && (idx_q == 2'd3)) begin
            snap_d[0] = seg1;
            snap_d[1] = seg2;
            snap_d[2] = seg3;
            snap_d[3] = seg4;
        end
        if (in_blank_c) begin
            dig_en_d  = '0;
            seg_out_d = SEG_OFF;
        end else begin
            dig_en_d  = 4'b0001 << idx_q;
            seg_out_d = snap_q[idx_q] ^ SEG_OFF;
        end
    end

    assign seg_out = seg_out_q;
    assign dig_en  = dig_en_q;

    drop_actuator #(
        .DROP_PULSE    (DROP_PULSE),
        .DROP_COOLDOWN (DROP_COOLDOWN)
    ) u_drop_actuator (
        .clk      (clk),
        .rst      (rst),
        .drop_req (drop_req),
        .solenoid (solenoid),
        .busy     (busy)
    );

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver against a time-based reference model.
module tb_display_scan_driver;

    localparam int unsigned DIV = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned P = 3;
    localparam int unsigned C = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg1, seg2, seg3, seg4;
    logic       drop_req;
    logic [6:0] seg_out, seg_out_al;
    logic [3:0] dig_en, dig_en_al;
    logic       solenoid, busy, solenoid_al, busy_al;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    display_scan_driver #(.DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(0),
                          .DROP_PULSE(P), .DROP_COOLDOWN(C)) u_dut (
        .clk(clk), .rst(rst), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .drop_req(drop_req), .seg_out(seg_out), .dig_en(dig_en),
        .solenoid(solenoid), .busy(busy));

    display_scan_driver #(.DIV(DIV), .BLANK(BLANK), .SEG_ACTIVE_LOW(1),
                          .DROP_PULSE(P), .DROP_COOLDOWN(C)) u_dut_al (
        .clk(clk), .rst(rst), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .drop_req(drop_req), .seg_out(seg_out_al), .dig_en(dig_en_al),
        .solenoid(solenoid_al), .busy(busy_al));

    // Reference model: position in the scan is cycles-since-reset; the actuator
    // is described by the time of the last accepted edge.
    int unsigned m_n;
    longint      m_t = 0;
    longint      m_fs = 0;
    bit          m_fired;
    bit          m_prev;
    logic [6:0]  m_snap [4];
    logic [6:0]  exp_seg, exp_seg_al;
    logic [3:0]  exp_en;
    logic        exp_sol, exp_busy;

    always @(posedge clk) begin
        int unsigned c, d;
        if (rst) begin
            m_n = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 7'h00;
            exp_en = 4'b0000; exp_seg = 7'h00; exp_seg_al = 7'h7F;
            m_prev = 1'b1; m_fired = 1'b0; exp_sol = 1'b0; exp_busy = 1'b0;
        end else begin
            c = m_n % DIV;
            d = (m_n / DIV) % 4;
            if (c < BLANK) begin
                exp_en = 4'b0000; exp_seg = 7'h00; exp_seg_al = 7'h7F;
            end else begin
                exp_en = 4'b0001 << d; exp_seg = m_snap[d]; exp_seg_al = ~m_snap[d];
            end
            if (c == DIV - 1 && d == 3) begin
                m_snap[0] = seg1; m_snap[1] = seg2; m_snap[2] = seg3; m_snap[3] = seg4;
            end
            m_n++;
            // The actuator is busy after edges fs..fs+P+C-1, so it can accept from fs+P+C+1
            if (drop_req && !m_prev && (!m_fired || m_t >= m_fs + P + C + 1)) begin
                m_fired = 1'b1;
                m_fs = m_t;
            end
            m_prev = drop_req;
            exp_sol  = m_fired && (m_t - m_fs) < P;
            exp_busy = m_fired && (m_t - m_fs) < P + C;
        end
        m_t++;
    end

    task automatic test_reset;
        rst = 1'b1; drop_req = 1'b0;
        seg1 = 7'h39; seg2 = 7'h5C; seg3 = 7'h38; seg4 = 7'h5E;
        repeat (3) @(negedge clk);
        n_tests++; if (seg_out !== 7'h00) begin n_fail++; $display("FAIL reset_seg: got %h want 00", seg_out); end
        n_tests++; if (dig_en !== 4'b0000) begin n_fail++; $display("FAIL reset_en: got %b want 0000", dig_en); end
        n_tests++; if (solenoid !== 1'b0) begin n_fail++; $display("FAIL reset_sol: got %b want 0", solenoid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (seg_out_al !== 7'h7F) begin n_fail++; $display("FAIL reset_seg_al: got %h want 7f", seg_out_al); end
        rst = 1'b0;
    endtask

    task automatic test_scan;
        int en_cnt [4];
        logic [6:0] codes [4];
        codes[0] = 7'h39; codes[1] = 7'h5C; codes[2] = 7'h38; codes[3] = 7'h5E;
        for (int i = 0; i < 4; i++) en_cnt[i] = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_tests++;
            if (dig_en !== 4'b0000 && seg_out !== 7'h00) begin
                n_fail++; $display("FAIL first_frame_blank cyc %0d: en %b seg %h want seg 00", k, dig_en, seg_out);
            end
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_tests++;
            if (dig_en !== exp_en || seg_out !== exp_seg) begin
                n_fail++; $display("FAIL scan_frame2 cyc %0d: en %b seg %h want en %b seg %h", k, dig_en, seg_out, exp_en, exp_seg);
            end
            for (int i = 0; i < 4; i++) begin
                if (dig_en === (4'b0001 << i)) begin
                    en_cnt[i]++;
                    n_tests++;
                    if (seg_out !== codes[i]) begin
                        n_fail++; $display("FAIL scan_code d%0d: got %h want %h", i, seg_out, codes[i]);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (en_cnt[i] != DIV - BLANK) begin
                n_fail++; $display("FAIL lit_count d%0d: got %0d want %0d", i, en_cnt[i], DIV - BLANK);
            end
        end
    endtask

    task automatic test_mid_frame_change;
        int phase = 0;
        int guard = 0;
        while (exp_en !== 4'b0010 && guard < 64) begin @(negedge clk); guard++; end
        n_tests++;
        if (guard >= 64) begin n_fail++; $display("FAIL midframe_sync: timeout got en %b want 0010", exp_en); end
        seg3 = 7'h06;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (dig_en === 4'b0001) phase = 1;
            if (dig_en === 4'b0100) begin
                n_tests++;
                if (seg_out !== (phase == 0 ? 7'h38 : 7'h06)) begin
                    n_fail++; $display("FAIL midframe_d3 phase %0d: got %h want %h", phase, seg_out, (phase == 0 ? 7'h38 : 7'h06));
                end
            end
            n_tests++;
            if (dig_en !== exp_en || seg_out !== exp_seg) begin
                n_fail++; $display("FAIL midframe_model: en %b seg %h want en %b seg %h", dig_en, seg_out, exp_en, exp_seg);
            end
        end
    endtask

    task automatic test_active_low;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (dig_en_al === 4'b0000) begin
                n_tests++;
                if (seg_out_al !== 7'h7F) begin n_fail++; $display("FAIL al_blank: got %h want 7f", seg_out_al); end
            end
            if (dig_en_al === 4'b0001) begin
                n_tests++;
                if (seg_out_al !== 7'h46) begin n_fail++; $display("FAIL al_digit1: got %h want 46", seg_out_al); end
            end
            n_tests++;
            if (seg_out_al !== exp_seg_al || dig_en_al !== exp_en) begin
                n_fail++; $display("FAIL al_model: seg %h en %b want seg %h en %b", seg_out_al, dig_en_al, exp_seg_al, exp_en);
            end
        end
    endtask

    task automatic test_drop_pulse;
        int sol_hi = 0;
        int busy_hi = 0;
        drop_req = 1'b0;
        @(negedge clk);
        drop_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_tests++;
                if (solenoid !== 1'b1 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL drop_latency: sol %b busy %b want 1 1", solenoid, busy);
                end
            end
            if (solenoid === 1'b1) sol_hi++;
            if (busy === 1'b1) busy_hi++;
            n_tests++;
            if (solenoid !== exp_sol || busy !== exp_busy) begin
                n_fail++; $display("FAIL drop_model cyc %0d: sol %b busy %b want %b %b", k, solenoid, busy, exp_sol, exp_busy);
            end
        end
        n_tests++;
        if (sol_hi != P) begin n_fail++; $display("FAIL drop_sol_width: got %0d want %0d", sol_hi, P); end
        n_tests++;
        if (busy_hi != P + C) begin n_fail++; $display("FAIL drop_busy_width: got %0d want %0d", busy_hi, P + C); end
    endtask

    task automatic test_lockout;
        bit pat [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                         1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int pulses = 0;
        logic sol_prev = 1'b0;
        drop_req = 1'b0;
        repeat (12) @(negedge clk);
        for (int k = 0; k < 26; k++) begin
            drop_req = (k < 16) ? pat[k] : 1'b1;
            @(negedge clk);
            if (solenoid === 1'b1 && sol_prev === 1'b0) pulses++;
            sol_prev = solenoid;
            n_tests++;
            if (solenoid !== exp_sol || busy !== exp_busy) begin
                n_fail++; $display("FAIL lockout_model cyc %0d: sol %b busy %b want %b %b", k, solenoid, busy, exp_sol, exp_busy);
            end
        end
        n_tests++;
        if (pulses != 2) begin n_fail++; $display("FAIL lockout_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_reset_during_fire;
        drop_req = 1'b0;
        repeat (12) @(negedge clk);
        drop_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if (solenoid !== 1'b1) begin n_fail++; $display("FAIL rstfire_pre: sol %b want 1", solenoid); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (solenoid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstfire_abort: sol %b busy %b want 0 0", solenoid, busy);
        end
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_tests++;
            if (solenoid !== 1'b0) begin n_fail++; $display("FAIL held_across_reset cyc %0d: sol %b want 0", k, solenoid); end
        end
        drop_req = 1'b0;
        @(negedge clk);
        drop_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if (solenoid !== 1'b1) begin n_fail++; $display("FAIL refire_after_reset: sol %b want 1", solenoid); end
    endtask

    task automatic test_random;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3, 0) == 0) drop_req = ~drop_req;
            if ($urandom_range(40, 0) == 0) begin
                seg1 = 7'($urandom); seg2 = 7'($urandom); seg3 = 7'($urandom); seg4 = 7'($urandom);
            end
            rst = ($urandom_range(300, 0) == 0);
            @(negedge clk);
            n_tests++;
            if (seg_out !== exp_seg || dig_en !== exp_en || solenoid !== exp_sol || busy !== exp_busy ||
                seg_out_al !== exp_seg_al || dig_en_al !== exp_en || solenoid_al !== exp_sol || busy_al !== exp_busy) begin
                n_fail++;
                $display("FAIL random cyc %0d: seg %h en %b sol %b busy %b seg_al %h want seg %h en %b sol %b busy %b seg_al %h",
                         k, seg_out, dig_en, solenoid, busy, seg_out_al, exp_seg, exp_en, exp_sol, exp_busy, exp_seg_al);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; drop_req = 1'b0;
        seg1 = 7'h00; seg2 = 7'h00; seg3 = 7'h00; seg4 = 7'h00;
        @(negedge clk);
        test_reset;
        test_scan;
        test_mid_frame_change;
        test_active_low;
        test_drop_pulse;
        test_lockout;
        test_reset_during_fire;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
